sd_sector_write_feeder: RTL and testbench

- 512-byte sector staging buffer and sequencer that sits directly upstream of the SD sector writer.
- The host (GPU bus side) fills the buffer byte-by-byte, then requests a write of one sector number.
- The block pulses the writer's start, serves bytes to the writer's 4-bit byte-pointer / byte-input interface, checks the CRC status, retries on failure, and reports done/error to the host.

---
 rtl/sd_sector_write_feeder_if.sv | 41 ++++
 rtl/sd_sector_write_feeder.sv | 150 +++++++++++++++
 tb/tb_sd_sector_write_feeder.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_sector_write_feeder_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sd_sector_write_feeder_if                                      |
// | Purpose : host-side and writer-side signal bundle of the sector feeder.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface sd_sector_write_feeder_if;
  logic        host_we;
  logic [8:0]  host_addr;
  logic [7:0]  host_wdata;
  logic [31:0] host_sector;
  logic        host_go;
  logic        host_ready;
  logic        host_done;
  logic        host_err;
  logic [1:0]  host_retries;
  logic        wstart;
  logic [31:0] wsector_no;
  logic        wbusy;
  logic        wdone;
  logic        crc_ok;
  logic [3:0]  bytePtr;
  logic [7:0]  wbyte;

  // master: host plus SD writer side; slave: the feeder itself
  modport master (
    output host_we, host_addr, host_wdata, host_sector, host_go,
    output wbusy, wdone, crc_ok, bytePtr,
    input  host_ready, host_done, host_err, host_retries,
    input  wstart, wsector_no, wbyte
  );

  modport slave (
    input  host_we, host_addr, host_wdata, host_sector, host_go,
    input  wbusy, wdone, crc_ok, bytePtr,
    output host_ready, host_done, host_err, host_retries,
    output wstart, wsector_no, wbyte
  );
endinterface
`default_nettype wire

// File: rtl/sd_sector_write_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sd_sector_write_feeder                                         |
// | Purpose : 512-byte sector buffer plus write/retry sequencer for the SD   |
// |           sector writer.                                                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sd_sector_write_feeder #(
  parameter int MAX_RETRY   = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  wire logic clk,
  input  wire logic rst_n,
  sd_sector_write_feeder_if.slave bus
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_ACK      = 3'd2,
    S_RUN      = 3'd3,
    S_WAITIDLE = 3'd4,
    S_FINISH   = 3'd5
  } state_t;

  state_t         state_q;
  logic [7:0]     mem [0:511];
  logic [4:0]     seg_q;
  logic [3:0]     prev_ptr_q;
  logic [TW-1:0]  timer_q;
  logic [7:0]     retry_q;
  logic           host_ready_q;
  logic           host_done_q;
  logic           host_err_q;
  logic [1:0]     host_retries_q;
  logic           wstart_q;
  logic [31:0]    wsector_q;
  logic [7:0]     wbyte_q;

  logic           w_retry;
  logic [1:0]     w_retries_sat;

  assign w_retry       = !bus.crc_ok && (retry_q < 8'(MAX_RETRY));
  assign w_retries_sat = (retry_q > 8'd3) ? 2'd3 : retry_q[1:0];

  // Buffer is only writable while idle, so the writer never sees a torn sector.
  always_ff @(posedge clk) begin
    if (bus.host_we && host_ready_q)
      mem[bus.host_addr] <= bus.host_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wbyte_q <= 8'h00;
    else
      wbyte_q <= mem[{seg_q, bus.bytePtr}];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      seg_q          <= 5'd0;
      prev_ptr_q     <= 4'd0;
      timer_q        <= '0;
      retry_q        <= 8'd0;
      host_ready_q   <= 1'b1;
      host_done_q    <= 1'b0;
      host_err_q     <= 1'b0;
      host_retries_q <= 2'd0;
      wstart_q       <= 1'b0;
      wsector_q      <= 32'd0;
    end else begin
      prev_ptr_q <= bus.bytePtr;
      // A pointer wrap 15->0 means the writer moved on to the next 16-byte segment.
      if (state_q == S_RUN && prev_ptr_q == 4'hF && bus.bytePtr == 4'h0)
        seg_q <= seg_q + 5'd1;

      case (state_q)
        S_IDLE: begin
          if (bus.host_go) begin
            wsector_q    <= bus.host_sector;
            retry_q      <= 8'd0;
            wstart_q     <= 1'b1;
            host_ready_q <= 1'b0;
            state_q      <= S_START;
          end
        end
        S_START: begin
          wstart_q   <= 1'b0;
          seg_q      <= 5'd0;
          prev_ptr_q <= 4'd0;
          timer_q    <= '0;
          state_q    <= S_ACK;
        end
        S_ACK, S_RUN: begin
          if (bus.wdone) begin
            if (w_retry) begin
              retry_q <= retry_q + 8'd1;
              state_q <= S_WAITIDLE;
            end else begin
              host_done_q    <= 1'b1;
              host_err_q     <= !bus.crc_ok;
              host_retries_q <= w_retries_sat;
              state_q        <= S_FINISH;
            end
          end else if (state_q == S_ACK) begin
            if (bus.wbusy) begin
              state_q <= S_RUN;
            end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
              host_done_q    <= 1'b1;
              host_err_q     <= 1'b1;
              host_retries_q <= w_retries_sat;
              state_q        <= S_FINISH;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
        end
        S_WAITIDLE: begin
          if (!bus.wbusy) begin
            wstart_q <= 1'b1;
            state_q  <= S_START;
          end
        end
        S_FINISH: begin
          host_done_q  <= 1'b0;
          host_ready_q <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: begin
          host_ready_q <= 1'b1;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.host_ready   = host_ready_q;
  assign bus.host_done    = host_done_q;
  assign bus.host_err     = host_err_q;
  assign bus.host_retries = host_retries_q;
  assign bus.wstart       = wstart_q;
  assign bus.wsector_no   = wsector_q;
  assign bus.wbyte        = wbyte_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_sector_write_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_sd_sector_write_feeder                                      |
// | Purpose : directed bench with a behavioural buffer/outcome model.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sd_sector_write_feeder;
  localparam int MAX_RETRY   = 2;
  localparam int ACK_TIMEOUT = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sd_sector_write_feeder_if bus();

  sd_sector_write_feeder #(.MAX_RETRY(MAX_RETRY), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  model_mem [512];
  logic        exp_valid  = 1'b0;
  int          exp_idx    = 0;
  logic [31:0] exp_sector = 32'd0;
  logic        cur_err    = 1'b0;
  logic [1:0]  cur_ret    = 2'd0;
  int          cur_starts = 0;
  logic        held_err   = 1'b0;
  logic [1:0]  held_ret   = 2'd0;
  int          wstart_cnt = 0;
  int          done_cnt   = 0;
  int          cyc        = 0;
  int          wstart_cyc = 0;
  int          done_cyc   = 0;
  logic        in_op      = 1'b0;
  logic        prev_wstart = 1'b0;
  logic        prev_done   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      in_op       = 1'b0;
      prev_wstart = 1'b0;
      prev_done   = 1'b0;
    end else begin
      if (exp_valid)
        check("wbyte", {24'd0, bus.wbyte}, {24'd0, model_mem[exp_idx]});
      if (bus.wstart) begin
        check("wstart_width", {31'd0, prev_wstart}, 32'd0);
        wstart_cnt++;
        wstart_cyc = cyc;
        in_op      = 1'b1;
      end
      if (in_op) begin
        check("ready_low_busy", {31'd0, bus.host_ready}, 32'd0);
        check("wsector_no", bus.wsector_no, exp_sector);
      end
      if (bus.host_done) begin
        check("done_width", {31'd0, prev_done}, 32'd0);
        check("host_err", {31'd0, bus.host_err}, {31'd0, cur_err});
        check("host_retries", {30'd0, bus.host_retries}, {30'd0, cur_ret});
        check("wstart_count", wstart_cnt, cur_starts);
        done_cnt++;
        done_cyc = cyc;
        in_op    = 1'b0;
        held_err = cur_err;
        held_ret = cur_ret;
      end else begin
        check("err_hold", {31'd0, bus.host_err}, {31'd0, held_err});
        check("ret_hold", {30'd0, bus.host_retries}, {30'd0, held_ret});
      end
      prev_wstart = bus.wstart;
      prev_done   = bus.host_done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Writer model: acknowledges, sweeps bytePtr (3 clk per byte), then reports CRC.
  task automatic run_attempt(input bit ack, input bit crc, input int nbytes,
                             input bit poke, input bit finish);
    int n;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.wstart) break;
    end
    if (n == 100) check("wstart_seen", 32'd0, 32'd1);
    tick();
    if (!ack) return;
    bus.wbusy = 1'b1;
    tick();
    if (poke) begin
      bus.host_we     = 1'b1;
      bus.host_addr   = 9'd5;
      bus.host_wdata  = 8'hAA;
      bus.host_go     = 1'b1;
      bus.host_sector = 32'hDEAD_BEEF;
      tick();
      bus.host_we = 1'b0;
      bus.host_go = 1'b0;
    end
    for (int k = 0; k < nbytes; k++) begin
      bus.bytePtr = 4'(k % 16);
      tick();
      tick();
      exp_idx   = k;
      exp_valid = 1'b1;
      tick();
      exp_valid = 1'b0;
    end
    if (!finish) return;
    bus.wdone  = 1'b1;
    bus.crc_ok = crc;
    tick();
    bus.wdone   = 1'b0;
    bus.crc_ok  = 1'b0;
    bus.wbusy   = 1'b0;
    bus.bytePtr = 4'd0;
  endtask

  task automatic run_op(input logic [31:0] sector, input int nfail, input bit ack,
                        input int nbytes, input bit poke);
    int d0;
    int n;
    // Outcome model: attempts stop at first good CRC or after MAX_RETRY re-issues.
    if (!ack) begin
      cur_err = 1'b1; cur_ret = 2'd0; cur_starts = 1;
    end else if (nfail > MAX_RETRY) begin
      cur_err = 1'b1; cur_ret = 2'(MAX_RETRY); cur_starts = MAX_RETRY + 1;
    end else begin
      cur_err = 1'b0; cur_ret = 2'(nfail); cur_starts = nfail + 1;
    end
    wstart_cnt = 0;
    exp_sector = sector;
    d0 = done_cnt;
    check("ready_before_go", {31'd0, bus.host_ready}, 32'd1);
    bus.host_go     = 1'b1;
    bus.host_sector = sector;
    bus.host_we     = 1'b1;
    bus.host_addr   = 9'd0;
    bus.host_wdata  = 8'h00;
    model_mem[0]    = 8'h00;
    tick();
    bus.host_go = 1'b0;
    bus.host_we = 1'b0;
    if (!ack)
      run_attempt(1'b0, 1'b0, 0, 1'b0, 1'b1);
    else
      for (int a = 0; a < cur_starts; a++)
        run_attempt(1'b1, a >= nfail, nbytes, poke && (a == 0), 1'b1);
    for (n = 0; n < 200; n++) begin
      if (done_cnt != d0) break;
      tick();
    end
    check("done_seen", done_cnt - d0, 32'd1);
    check("ready_after_done", {31'd0, bus.host_ready}, 32'd1);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.host_we = 1'b0; bus.host_addr = 9'd0; bus.host_wdata = 8'd0;
    bus.host_sector = 32'd0; bus.host_go = 1'b0;
    bus.wbusy = 1'b0; bus.wdone = 1'b0; bus.crc_ok = 1'b0; bus.bytePtr = 4'd0;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    check("rst_ready",   {31'd0, bus.host_ready}, 32'd1);
    check("rst_done",    {31'd0, bus.host_done}, 32'd0);
    check("rst_err",     {31'd0, bus.host_err}, 32'd0);
    check("rst_retries", {30'd0, bus.host_retries}, 32'd0);
    check("rst_wstart",  {31'd0, bus.wstart}, 32'd0);
    check("rst_wsector", bus.wsector_no, 32'd0);
    check("rst_wbyte",   {24'd0, bus.wbyte}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Fill with mem[i]=i; byte 0 gets a decoy that the go-cycle write overrides.
    for (int i = 0; i < 512; i++) begin
      bus.host_we    = 1'b1;
      bus.host_addr  = 9'(i);
      bus.host_wdata = (i == 0) ? 8'h5A : 8'(i);
      model_mem[i]   = (i == 0) ? 8'h5A : 8'(i);
      tick();
    end
    bus.host_we = 1'b0;

    // Normal write, with an ignored write/go poke while busy.
    run_op(32'h0000_1234, 0, 1'b1, 512, 1'b1);
    check("t1_err", {31'd0, bus.host_err}, 32'd0);
    check("t1_retries", {30'd0, bus.host_retries}, 32'd0);
    check("t1_sector", bus.wsector_no, 32'h0000_1234);

    // Two CRC failures, then success.
    run_op(32'h0000_2000, 2, 1'b1, 48, 1'b0);
    check("t2_err", {31'd0, bus.host_err}, 32'd0);
    check("t2_retries", {30'd0, bus.host_retries}, 32'd2);
    check("t2_starts", wstart_cnt, 32'd3);

    // Retries exhausted.
    run_op(32'h0000_3000, 3, 1'b1, 48, 1'b0);
    check("t3_err", {31'd0, bus.host_err}, 32'd1);
    check("t3_retries", {30'd0, bus.host_retries}, 32'd2);
    check("t3_starts", wstart_cnt, 32'd3);

    // No acknowledge: 16 ACK cycles after the start cycle, then done.
    run_op(32'h0000_4000, 0, 1'b0, 0, 1'b0);
    check("t4_latency", done_cyc - wstart_cyc, 32'd17);
    repeat (20) tick();
    check("t4_starts", wstart_cnt, 32'd1);
    check("t4_err", {31'd0, bus.host_err}, 32'd1);

    // Reset in the middle of segment 7.
    exp_sector      = 32'h0000_5000;
    wstart_cnt      = 0;
    bus.host_go     = 1'b1;
    bus.host_sector = 32'h0000_5000;
    tick();
    bus.host_go = 1'b0;
    run_attempt(1'b1, 1'b1, 120, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n       = 1'b0;
    exp_valid   = 1'b0;
    bus.wbusy   = 1'b0;
    bus.bytePtr = 4'd0;
    held_err    = 1'b0;
    held_ret    = 2'd0;
    #1;
    check("t5_ready",   {31'd0, bus.host_ready}, 32'd1);
    check("t5_wstart",  {31'd0, bus.wstart}, 32'd0);
    check("t5_wbyte",   {24'd0, bus.wbyte}, 32'd0);
    check("t5_err",     {31'd0, bus.host_err}, 32'd0);
    check("t5_wsector", bus.wsector_no, 32'd0);
    check("t5_seg",     {27'd0, dut.seg_q}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Normal operation after reset; buffer contents retained.
    run_op(32'hCAFE_0001, 0, 1'b1, 512, 1'b0);
    check("t6_err", {31'd0, bus.host_err}, 32'd0);
    check("t6_sector", bus.wsector_no, 32'hCAFE_0001);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
